// File: rtl/control_pkg.sv
// Shared definitions for the control sequencer: opcodes, microstep indices and
// control-word bit positions.
package control_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LDA = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_STA = 4'd4,
        OP_LDI = 4'd5,
        OP_JMP = 4'd6,
        OP_JC  = 4'd7,
        OP_JZ  = 4'd8,
        OP_OUT = 4'd14,
        OP_HLT = 4'd15
    } opcode_t;

    localparam int unsigned T0 = 0;
    localparam int unsigned T1 = 1;
    localparam int unsigned T2 = 2;
    localparam int unsigned T3 = 3;
    localparam int unsigned T4 = 4;

    localparam int unsigned CW_HALT      = 16;
    localparam int unsigned CW_MAR_IN    = 15;
    localparam int unsigned CW_RAM_IN    = 14;
    localparam int unsigned CW_RAM_OUT   = 13;
    localparam int unsigned CW_IR_IN     = 12;
    localparam int unsigned CW_IR_OUT    = 11;
    localparam int unsigned CW_LOAD_A    = 10;
    localparam int unsigned CW_WRITE_A   = 9;
    localparam int unsigned CW_LOAD_B    = 8;
    localparam int unsigned CW_WRITE_B   = 7;
    localparam int unsigned CW_WRITE_ALU = 6;
    localparam int unsigned CW_SUBTRACT  = 5;
    localparam int unsigned CW_OUT_LOAD  = 4;
    localparam int unsigned CW_PC_ENABLE = 3;
    localparam int unsigned CW_PC_OUT    = 2;
    localparam int unsigned CW_JUMP      = 1;
    localparam int unsigned CW_FLAGS_IN  = 0;
    localparam int unsigned CW_W         = 17;

endpackage

// File: rtl/control_sequencer_if.sv
// Control-word, ALU flag and debug signals between the sequencer and the
// bus-attached blocks; the sequencer takes the master side.
interface control_sequencer_if #(
    parameter int unsigned STEP_W = 3
);
    logic              carry;
    logic              zero;
    logic              halt;
    logic              mar_in;
    logic              ram_in;
    logic              ram_out;
    logic              ir_in;
    logic              ir_out;
    logic              load_A;
    logic              write_A;
    logic              load_B;
    logic              write_B;
    logic              write_ALU;
    logic              subtract;
    logic              out_load;
    logic              pc_enable;
    logic              pc_out;
    logic              jump;
    logic              flags_in;
    logic [STEP_W-1:0] step;
    logic              flag_c;
    logic              flag_z;

    modport master (
        input  carry, zero,
        output halt, mar_in, ram_in, ram_out, ir_in, ir_out, load_A, write_A,
               load_B, write_B, write_ALU, subtract, out_load, pc_enable,
               pc_out, jump, flags_in, step, flag_c, flag_z
    );

    modport slave (
        output carry, zero,
        input  halt, mar_in, ram_in, ram_out, ir_in, ir_out, load_A, write_A,
               load_B, write_B, write_ALU, subtract, out_load, pc_enable,
               pc_out, jump, flags_in, step, flag_c, flag_z
    );
endinterface

// File: rtl/microcode_decoder.sv
// Combinational microcode ROM: {opcode, step, flags} -> control word, plus a
// marker for the last non-empty step of the instruction.
module microcode_decoder
    import control_pkg::*;
#(
    parameter int unsigned STEP_W = 3
) (
    input  opcode_t           opcode,
    input  logic [STEP_W-1:0] step,
    input  logic              flag_c,
    input  logic              flag_z,
    output logic [CW_W-1:0]   cw,
    output logic              last_step
);

    int unsigned s;
    assign s = 32'(step);

    always_comb begin
        cw        = '0;
        last_step = 1'b0;
        if (s == T0) begin
            cw[CW_PC_OUT] = 1'b1;
            cw[CW_MAR_IN] = 1'b1;
        end else if (s == T1) begin
            cw[CW_RAM_OUT]   = 1'b1;
            cw[CW_IR_IN]     = 1'b1;
            cw[CW_PC_ENABLE] = 1'b1;
        end else begin
            case (opcode)
                OP_LDA: begin
                    if (s == T2) begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_MAR_IN] = 1'b1;
                    end else if (s == T3) begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_LOAD_A]  = 1'b1;
                        last_step      = 1'b1;
                    end
                end
                OP_ADD, OP_SUB: begin
                    if (s == T2) begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_MAR_IN] = 1'b1;
                    end else if (s == T3) begin
                        cw[CW_RAM_OUT]  = 1'b1;
                        cw[CW_LOAD_B]   = 1'b1;
                        cw[CW_SUBTRACT] = (opcode == OP_SUB);
                    end else if (s == T4) begin
                        cw[CW_WRITE_ALU] = 1'b1;
                        cw[CW_LOAD_A]    = 1'b1;
                        cw[CW_FLAGS_IN]  = 1'b1;
                        cw[CW_SUBTRACT]  = (opcode == OP_SUB);
                        last_step        = 1'b1;
                    end
                end
                OP_STA: begin
                    if (s == T2) begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_MAR_IN] = 1'b1;
                    end else if (s == T3) begin
                        cw[CW_WRITE_A] = 1'b1;
                        cw[CW_RAM_IN]  = 1'b1;
                        last_step      = 1'b1;
                    end
                end
                OP_LDI: begin
                    if (s == T2) begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_LOAD_A] = 1'b1;
                        last_step     = 1'b1;
                    end
                end
                OP_JMP: begin
                    if (s == T2) begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_JUMP]   = 1'b1;
                        last_step     = 1'b1;
                    end
                end
                // Conditional jumps end at T2 whether or not they are taken.
                OP_JC: begin
                    if (s == T2) begin
                        cw[CW_IR_OUT] = flag_c;
                        cw[CW_JUMP]   = flag_c;
                        last_step     = 1'b1;
                    end
                end
                OP_JZ: begin
                    if (s == T2) begin
                        cw[CW_IR_OUT] = flag_z;
                        cw[CW_JUMP]   = flag_z;
                        last_step     = 1'b1;
                    end
                end
                OP_OUT: begin
                    if (s == T2) begin
                        cw[CW_WRITE_A] = 1'b1;
                        cw[CW_OUT_LOAD] = 1'b1;
                        last_step       = 1'b1;
                    end
                end
                OP_HLT: begin
                    if (s == T2) begin
                        cw[CW_HALT] = 1'b1;
                    end
                end
                default: begin
                    if (s == T2) begin
                        last_step = 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control unit: instruction register, microstep counter and flags.
// Optional macro CONTROL_SEQUENCER_EARLY_STEP_RESET_EN ends each instruction after its last non-empty step.
module control_sequencer
    import control_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEPS = 5
) (
    input  logic                 clk,
    input  logic                 clr_n,
    inout  logic [WIDTH-1:0]     bus,
    control_sequencer_if.master  ctl
);

    localparam int unsigned STEP_W = $clog2(STEPS);

    logic [WIDTH-1:0]  ir, ir_next;
    logic [STEP_W-1:0] step, step_next;
    logic              flag_c, flag_c_next;
    logic              flag_z, flag_z_next;
    logic              halted, halted_next;
    logic [CW_W-1:0]   cw;
    logic              freeze;
    opcode_t           opcode;

    assign opcode = opcode_t'(ir[WIDTH-1 -: 4]);

`ifdef CONTROL_SEQUENCER_EARLY_STEP_RESET_EN
    logic last_step;

    microcode_decoder #(
        .STEP_W (STEP_W)
    ) u_decoder (
        .opcode    (opcode),
        .step      (step),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .cw        (cw),
        .last_step (last_step)
    );
`else
    microcode_decoder #(
        .STEP_W (STEP_W)
    ) u_decoder (
        .opcode    (opcode),
        .step      (step),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .cw        (cw),
        .last_step ()
    );
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ir     <= '0;
            step   <= '0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            halted <= 1'b0;
        end else begin
            ir     <= ir_next;
            step   <= step_next;
            flag_c <= flag_c_next;
            flag_z <= flag_z_next;
            halted <= halted_next;
        end
    end

    // HLT at T2 freezes everything on the same edge it is first decoded.
    assign freeze = halted | cw[CW_HALT];

    always_comb begin
        ir_next     = ir;
        step_next   = step;
        flag_c_next = flag_c;
        flag_z_next = flag_z;
        halted_next = freeze;
        if (!freeze) begin
            if (cw[CW_IR_IN]) begin
                ir_next = bus;
            end
            if (cw[CW_FLAGS_IN]) begin
                flag_c_next = ctl.carry;
                flag_z_next = ctl.zero;
            end
`ifdef CONTROL_SEQUENCER_EARLY_STEP_RESET_EN
            if (last_step || step == STEP_W'(STEPS - 1)) begin
`else
            if (step == STEP_W'(STEPS - 1)) begin
`endif
                step_next = '0;
            end else begin
                step_next = step + 1'b1;
            end
        end
    end

    assign bus = cw[CW_IR_OUT] ? {{4{1'b0}}, ir[WIDTH-5:0]} : 'z;

    assign ctl.halt      = cw[CW_HALT] | halted;
    assign ctl.mar_in    = cw[CW_MAR_IN];
    assign ctl.ram_in    = cw[CW_RAM_IN];
    assign ctl.ram_out   = cw[CW_RAM_OUT];
    assign ctl.ir_in     = cw[CW_IR_IN];
    assign ctl.ir_out    = cw[CW_IR_OUT];
    assign ctl.load_A    = cw[CW_LOAD_A];
    assign ctl.write_A   = cw[CW_WRITE_A];
    assign ctl.load_B    = cw[CW_LOAD_B];
    assign ctl.write_B   = cw[CW_WRITE_B];
    assign ctl.write_ALU = cw[CW_WRITE_ALU];
    assign ctl.subtract  = cw[CW_SUBTRACT];
    assign ctl.out_load  = cw[CW_OUT_LOAD];
    assign ctl.pc_enable = cw[CW_PC_ENABLE];
    assign ctl.pc_out    = cw[CW_PC_OUT];
    assign ctl.jump      = cw[CW_JUMP];
    assign ctl.flags_in  = cw[CW_FLAGS_IN];
    assign ctl.step      = step;
    assign ctl.flag_c    = flag_c;
    assign ctl.flag_z    = flag_z;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: instruction-level model checked every cycle plus
// directed literal checks from the test plan.
module tb_control_sequencer;

    localparam logic [16:0] M_HALT  = 17'd1 << 16;
    localparam logic [16:0] M_MARI  = 17'd1 << 15;
    localparam logic [16:0] M_RAMI  = 17'd1 << 14;
    localparam logic [16:0] M_RAMO  = 17'd1 << 13;
    localparam logic [16:0] M_IRI   = 17'd1 << 12;
    localparam logic [16:0] M_IRO   = 17'd1 << 11;
    localparam logic [16:0] M_LDA   = 17'd1 << 10;
    localparam logic [16:0] M_WRA   = 17'd1 << 9;
    localparam logic [16:0] M_LDB   = 17'd1 << 8;
    localparam logic [16:0] M_WRB   = 17'd1 << 7;
    localparam logic [16:0] M_ALU   = 17'd1 << 6;
    localparam logic [16:0] M_SUB   = 17'd1 << 5;
    localparam logic [16:0] M_OUT   = 17'd1 << 4;
    localparam logic [16:0] M_PCEN  = 17'd1 << 3;
    localparam logic [16:0] M_PCO   = 17'd1 << 2;
    localparam logic [16:0] M_JMP   = 17'd1 << 1;
    localparam logic [16:0] M_FLG   = 17'd1 << 0;

    logic       clk = 1'b0;
    logic       clr_n = 1'b1;
    logic [7:0] ram_data = 8'h00;
    wire  [7:0] bus;
    int         vectors = 0;
    int         miscompares = 0;

    control_sequencer_if #(.STEP_W(3)) ctl();

    control_sequencer #(
        .WIDTH (8),
        .STEPS (5)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus),
        .ctl   (ctl)
    );

    always #5 clk = ~clk;

    // The bench plays RAM: it answers whenever the sequencer asks for RAM data.
    assign bus = ctl.ram_out ? ram_data : 8'hzz;

    logic [16:0] got_cw;
    assign got_cw = {ctl.halt, ctl.mar_in, ctl.ram_in, ctl.ram_out, ctl.ir_in,
                     ctl.ir_out, ctl.load_A, ctl.write_A, ctl.load_B, ctl.write_B,
                     ctl.write_ALU, ctl.subtract, ctl.out_load, ctl.pc_enable,
                     ctl.pc_out, ctl.jump, ctl.flags_in};

    // Execute-phase micro-operations, one row {T2,T3,T4} per opcode.
    function automatic logic [16:0] exec_word(input logic [3:0] op, input int t);
        logic [50:0] row;
        case (op)
            4'd1:  row = {M_IRO | M_MARI, M_RAMO | M_LDA, 17'd0};
            4'd2:  row = {M_IRO | M_MARI, M_RAMO | M_LDB, M_ALU | M_LDA | M_FLG};
            4'd3:  row = {M_IRO | M_MARI, M_RAMO | M_LDB | M_SUB, M_ALU | M_LDA | M_FLG | M_SUB};
            4'd4:  row = {M_IRO | M_MARI, M_WRA | M_RAMI, 17'd0};
            4'd5:  row = {M_IRO | M_LDA, 17'd0, 17'd0};
            4'd6,
            4'd7,
            4'd8:  row = {M_IRO | M_JMP, 17'd0, 17'd0};
            4'd14: row = {M_WRA | M_OUT, 17'd0, 17'd0};
            4'd15: row = {M_HALT, 17'd0, 17'd0};
            default: row = '0;
        endcase
        return row[(4 - t) * 17 +: 17];
    endfunction

    function automatic logic [16:0] mword(input logic [3:0] op, input int t,
                                          input logic fc, input logic fz);
        if (t == 0) return M_PCO | M_MARI;
        if (t == 1) return M_RAMO | M_IRI | M_PCEN;
        if ((op == 4'd7 && !fc) || (op == 4'd8 && !fz)) return '0;
        return exec_word(op, t);
    endfunction

    function automatic int ilen(input logic [3:0] op);
        int l;
        l = 5;
`ifdef CONTROL_SEQUENCER_EARLY_STEP_RESET_EN
        l = 3;
        for (int t = 2; t <= 4; t++) begin
            if (exec_word(op, t) != 17'd0) l = t + 1;
        end
`endif
        return (op == 4'd15) ? 5 : l;
    endfunction

    // Instruction-level model state.
    logic [7:0]  m_ir = 8'h00;
    logic [2:0]  m_step = 3'd0;
    logic        m_fc = 1'b0;
    logic        m_fz = 1'b0;
    logic        m_halt = 1'b0;
    logic [16:0] m_word;

    always_comb m_word = mword(m_ir[7:4], int'(m_step), m_fc, m_fz);

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_ir   <= 8'h00;
            m_step <= 3'd0;
            m_fc   <= 1'b0;
            m_fz   <= 1'b0;
            m_halt <= 1'b0;
        end else if (!m_halt) begin
            if ((m_word & M_HALT) != 17'd0) begin
                m_halt <= 1'b1;
            end else begin
                if ((m_word & M_IRI) != 17'd0) m_ir <= ram_data;
                if ((m_word & M_FLG) != 17'd0) begin
                    m_fc <= ctl.carry;
                    m_fz <= ctl.zero;
                end
                m_step <= (int'(m_step) + 1 >= ilen(m_ir[7:4])) ? 3'd0 : m_step + 3'd1;
            end
        end
    end

    always @(negedge clk) begin
        vectors++;
        if ({got_cw, ctl.step, ctl.flag_c, ctl.flag_z} !== {m_word, m_step, m_fc, m_fz}) begin
            miscompares++;
            $display("FAIL model_cycle t=%0t cw=%h step=%0d fc=%b fz=%b, required cw=%h step=%0d fc=%b fz=%b",
                     $time, got_cw, ctl.step, ctl.flag_c, ctl.flag_z, m_word, m_step, m_fc, m_fz);
        end
        if ((m_word & M_IRO) != 17'd0) begin
            vectors++;
            if (bus !== {4'h0, m_ir[3:0]}) begin
                miscompares++;
                $display("FAIL model_bus t=%0t bus=%h, required %h", $time, bus, {4'h0, m_ir[3:0]});
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start(input logic [7:0] ins, input logic c, input logic z);
        ram_data  = ins;
        ctl.carry = c;
        ctl.zero  = z;
    endtask

    task automatic run(input logic [7:0] ins, input logic c, input logic z);
        start(ins, c, z);
        ticks(ilen(ins[7:4]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ctl.carry = 1'b0;
        ctl.zero  = 1'b0;
        #3 clr_n = 1'b0;
        tick();
        chk("reset_cw", 32'(got_cw), 32'(M_MARI | M_PCO));
        chk("reset_step", 32'(ctl.step), 32'd0);
        chk("reset_flags", {30'd0, ctl.flag_c, ctl.flag_z}, 32'd0);
        start(8'h00, 1'b0, 1'b0);
        clr_n = 1'b1;

        // NOP step sequence
        begin
`ifdef CONTROL_SEQUENCER_EARLY_STEP_RESET_EN
            int seq [4] = '{0, 1, 2, 0};
`else
            int seq [6] = '{0, 1, 2, 3, 4, 0};
`endif
            foreach (seq[i]) begin
                chk("nop_step", 32'(ctl.step), 32'(seq[i]));
                if (i < $size(seq) - 1) tick();
            end
        end

        // LDI 0x57
        start(8'h57, 1'b0, 1'b0);
        ticks(2);
        chk("ldi_irout_loada", {30'd0, ctl.ir_out, ctl.load_A}, 32'd3);
        chk("ldi_bus", 32'(bus), 32'h07);
        ticks(ilen(4'd5) - 2);
        chk("ldi_done_step", 32'(ctl.step), 32'd0);

        // ADD 0x2E with carry=1, zero=0
        start(8'h2E, 1'b1, 1'b0);
        ticks(4);
        chk("add_t4", {29'd0, ctl.write_ALU, ctl.load_A, ctl.flags_in}, 32'd7);
        tick();
        chk("add_flags", {30'd0, ctl.flag_c, ctl.flag_z}, 32'd2);

        // SUB 0x3E with carry=0, zero=1
        start(8'h3E, 1'b0, 1'b1);
        ticks(3);
        chk("sub_t3", 32'(ctl.subtract), 32'd1);
        tick();
        chk("sub_t4", 32'(ctl.subtract), 32'd1);
        tick();
        chk("sub_flags", {30'd0, ctl.flag_c, ctl.flag_z}, 32'd1);

        // JC 0x73 not taken (flag_c=0)
        start(8'h73, 1'b0, 1'b0);
        ticks(2);
        chk("jc_nt", {30'd0, ctl.jump, ctl.ir_out}, 32'd0);
        ticks(ilen(4'd7) - 2);

        // Set carry, then JC taken
        run(8'h2E, 1'b1, 1'b0);
        start(8'h73, 1'b0, 1'b0);
        ticks(2);
        chk("jc_t", {30'd0, ctl.jump, ctl.ir_out}, 32'd3);
        chk("jc_bus", 32'(bus), 32'h03);
        ticks(ilen(4'd7) - 2);

        // Remaining opcodes, checked by the model
        run(8'h85, 1'b0, 1'b0);
        run(8'h1A, 1'b0, 1'b0);
        run(8'h4B, 1'b0, 1'b0);
        run(8'hE0, 1'b0, 1'b0);
        run(8'h6C, 1'b0, 1'b0);
        run(8'h9D, 1'b0, 1'b0);
        run(8'hC1, 1'b0, 1'b0);

        // Reset in the middle of ADD T3 (flag_c is 1 here)
        start(8'h2E, 1'b1, 1'b1);
        ticks(3);
        chk("pre_reset_step", 32'(ctl.step), 32'd3);
        clr_n = 1'b0;
        #1;
        chk("midreset_cw", 32'(got_cw), 32'(M_MARI | M_PCO));
        chk("midreset_step", 32'(ctl.step), 32'd0);
        chk("midreset_flags", {30'd0, ctl.flag_c, ctl.flag_z}, 32'd0);
        tick();
        start(8'hF0, 1'b1, 1'b1);
        clr_n = 1'b1;

        // HLT: freeze for 10 clocks while inputs wiggle
        ticks(2);
        chk("hlt_halt", 32'(ctl.halt), 32'd1);
        for (int i = 0; i < 10; i++) begin
            ram_data  = 8'(i * 37);
            ctl.carry = i[0];
            ctl.zero  = ~i[0];
            tick();
            chk("hlt_step", 32'(ctl.step), 32'd2);
            chk("hlt_still", 32'(ctl.halt), 32'd1);
            chk("hlt_flags", {30'd0, ctl.flag_c, ctl.flag_z}, 32'd0);
        end
        clr_n = 1'b0;
        #1;
        chk("hlt_cleared", 32'(ctl.halt), 32'd0);
        tick();
        start(8'h00, 1'b0, 1'b0);
        clr_n = 1'b1;
        run(8'h00, 1'b0, 1'b0);
        run(8'h5F, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcoded control unit for the 8-bit computer; sits directly upstream of the ALU and drives its load_A/load_B/write_A/write_B/write_ALU/subtract strobes.
- Holds the instruction register, the microstep counter and the flags register, which captures the ALU's carry/zero outputs.
- Emits one control word per clock to the bus-attached blocks: ALU, RAM, MAR, PC and output register.

Parameters:
- WIDTH, 8, bus/instruction width; opcode is the upper 4 bits, operand the lower WIDTH-4 bits.
- STEPS, 5, microsteps per instruction (T0..T4); the step counter is clog2(STEPS) bits wide.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr_n  input  1  asynchronous active-low reset.
- bus  inout  WIDTH  shared bus; IR loads from it; operand is driven onto it when ir_out is high, else Z.
- carry  input  1  ALU carry flag.
- zero  input  1  ALU zero flag.
- halt, mar_in, ram_in, ram_out, ir_in, ir_out, load_A, write_A, load_B, write_B, write_ALU, subtract, out_load, pc_enable, pc_out, jump, flags_in  output  1 each  control word.
- step  output  clog2(STEPS)  current microstep, for debug/display.
- flag_c, flag_z  output  1  registered flags.

Behaviour:
- Reset (clr_n=0, async): IR=0, step=0, flags=0, halted=0. Control word is then T0 fetch (mar_in=1, pc_out=1); all other outputs are 0 and bus is Z.
- Control word is combinational from {IR opcode, step, flag_c, flag_z}. IR, flags and step update on the rising edge.
- Fetch, all opcodes:
  - T0: pc_out, mar_in.
  - T1: ram_out, ir_in, pc_enable.
- Opcodes and execute steps T2..T4 (unlisted steps all-zero):
  - 0 NOP: none.
  - 1 LDA: ir_out+mar_in; ram_out+load_A.
  - 2 ADD: ir_out+mar_in; ram_out+load_B; write_ALU+load_A+flags_in.
  - 3 SUB: same as ADD, with subtract=1 in T3 and T4.
  - 4 STA: ir_out+mar_in; write_A+ram_in.
  - 5 LDI: ir_out+load_A.
  - 6 JMP: ir_out+jump.
  - 7 JC: ir_out+jump only if flag_c=1, else nothing.
  - 8 JZ: ir_out+jump only if flag_z=1.
  - 14 OUT: write_A+out_load.
  - 15 HLT: halt.
  - 9..13: behave as NOP.
- ir_out drives {4'b0, IR[3:0]} onto the bus (upper bits zero); when ir_out=0 the bus is Z.
- flags_in=1: flag_c<=carry and flag_z<=zero on that edge. Otherwise the flags hold.
- Step counter: increments each edge; wraps STEPS-1 -> 0.
- HLT: at T2 the step freezes and halt stays 1 until reset. IR and flags are frozen while halted.
- Simultaneous ir_in and reset: reset wins.
- Conditional jump evaluates the flags registered before the current edge.
- Exactly one bus driver per step by construction.

Optional Feature:
- Macro CONTROL_SEQUENCER_EARLY_STEP_RESET_EN.
- Defined: after the last non-empty step of an instruction, step returns to 0.
  - Last step is T2 for NOP/LDI/JMP/OUT, and for JC/JZ whether or not the jump is taken.
  - Last step is T3 for LDA/STA; T4 for ADD/SUB.
  - NOP therefore takes 3 cycles.
- Undefined: every instruction takes exactly STEPS cycles.

Decomposition:
- Shared package control_pkg holds:
  - opcode constants (OP_NOP..OP_HLT);
  - step constants T0..T4;
  - control-word bit index constants and the control-word width.
- Natural sub-module: microcode_decoder. It is purely combinational, {opcode, step, flags} -> control word plus last_step; control_sequencer instantiates it.

Test Plan:
- Reset: assert clr_n=0 mid-T3 of ADD -> step=0, IR=0, flags=0 immediately; mar_in=pc_out=1, all else 0.
- LDI: bus=0x57 at T1 -> T2 shows ir_out=1, load_A=1, bus=0x07. With the macro defined, step=0 on the next edge.
- ADD: IR=0x2E, carry=1, zero=0 at T4 -> write_ALU, load_A, flags_in high; next edge flag_c=1, flag_z=0. SUB shows subtract=1 in T3 and T4.
- JC: IR=0x73 with flag_c=0 -> T2 has jump=0, bus Z. With flag_c=1 -> jump=1, ir_out=1, bus=0x03.
- HLT: IR=0xF0 -> halt=1 from T2 onward; step, IR and flags unchanged for 10 clocks; clr_n pulse clears halt.
- Macro off: NOP cycles step 0,1,2,3,4,0; macro on: 0,1,2,0.
